// File: rtl/regfile_pkg.sv
// Shared types and constants for the register-file writeback path.
package regfile_pkg;

    localparam int NREG   = 16;
    localparam int ADDR_W = $clog2(NREG);
    localparam int DATA_W = 32;
    localparam int PC_IDX = 15;

    typedef logic [ADDR_W-1:0] reg_idx_t;
    typedef logic [DATA_W-1:0] reg_data_t;

    typedef enum logic {
        REQ_ALU = 1'b0,
        REQ_MEM = 1'b1
    } wb_src_t;

    // The PC has a dedicated update path and must never be written through here.
    function automatic logic is_pc(input reg_idx_t idx);
        return idx == reg_idx_t'(PC_IDX);
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter. The pointer only moves when both requesters
// compete, so a lone requester never disturbs the fairness order.
module rr_arb2
    import regfile_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    wb_src_t rr_ptr;

    // Grant decode: single requester wins outright, contention resolved by rr_ptr.
    always_comb begin
        gnt = 2'b00;
        if (!rst) begin
            case (req)
                2'b01:   gnt = 2'b01;
                2'b10:   gnt = 2'b10;
                2'b11:   gnt = (rr_ptr == REQ_MEM) ? 2'b10 : 2'b01;
                default: gnt = 2'b00;
            endcase
        end
    end

    // Pointer flips to the loser after every contested grant.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr <= REQ_ALU;
        end else if (req == 2'b11) begin
            rr_ptr <= (rr_ptr == REQ_ALU) ? REQ_MEM : REQ_ALU;
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the register file write port between the ALU and load unit and
// tracks outstanding writes in a busy scoreboard for issue-stage hazard checks.
module regfile_wb_arbiter
    import regfile_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              alu_valid,
    input  logic [ADDR_W-1:0] alu_addr,
    input  logic [DATA_W-1:0] alu_data,
    output logic              alu_ready,
    input  logic              mem_valid,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_data,
    output logic              mem_ready,
    input  logic              iss_valid,
    input  logic [ADDR_W-1:0] iss_addr,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic [NREG-1:0]   busy,
    output logic              pc_wr_err
);

    logic [1:0] gnt;
    wb_src_t    sel_p0;
    reg_idx_t   addr_p0;
    reg_data_t  data_p0;
    logic       acc_vld_p0;
    logic       pc_hit_p0;

    logic       wr_vld_p1;
    reg_idx_t   wr_addr_p1;
    reg_data_t  wr_data_p1;
    logic       pc_err_p1;

    logic [NREG-1:0] busy_q;
    logic [NREG-1:0] busy_nxt;

    rr_arb2 u_arb (
        .clk (clk),
        .rst (rst),
        .req ({mem_valid, alu_valid}),
        .gnt (gnt)
    );

    assign alu_ready = gnt[0];
    assign mem_ready = gnt[1];

    // ---- stage p0: grant mux and PC-target classification ----
    // Select the granted requester's payload and split accepted vs PC-targeted.
    always_comb begin
        sel_p0     = gnt[1] ? REQ_MEM : REQ_ALU;
        addr_p0    = (sel_p0 == REQ_MEM) ? mem_addr : alu_addr;
        data_p0    = (sel_p0 == REQ_MEM) ? mem_data : alu_data;
        acc_vld_p0 = (|gnt) && !is_pc(addr_p0);
        pc_hit_p0  = (|gnt) && is_pc(addr_p0);
    end

    // ---- stage p1: registered write-port drive ----
    // Address/data only reload on an accepted write so they hold between writes.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_vld_p1  <= 1'b0;
            pc_err_p1  <= 1'b0;
            wr_addr_p1 <= '0;
            wr_data_p1 <= '0;
        end else begin
            wr_vld_p1 <= acc_vld_p0;
            pc_err_p1 <= pc_hit_p0;
            if (acc_vld_p0) begin
                wr_addr_p1 <= addr_p0;
                wr_data_p1 <= data_p0;
            end
        end
    end

    assign wr_en     = wr_vld_p1;
    assign wr_addr   = wr_addr_p1;
    assign wr_data   = wr_data_p1;
    assign pc_wr_err = pc_err_p1;

    // Scoreboard next state: commit clears first, issue sets last so set wins.
    always_comb begin
        busy_nxt = busy_q;
        if (wr_vld_p1) begin
            busy_nxt[wr_addr_p1] = 1'b0;
        end
        if (iss_valid && !is_pc(iss_addr)) begin
            busy_nxt[iss_addr] = 1'b1;
        end
    end

    // Scoreboard register.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_nxt;
        end
    end

    assign busy = busy_q;

    // Issue logic must stall on busy; the only legal re-issue is onto the
    // register being committed at this very edge.
    ap_issue_not_busy: assert property (@(posedge clk) disable iff (rst)
        (iss_valid && (iss_addr != reg_idx_t'(PC_IDX)) && busy_q[iss_addr])
        |-> (wr_vld_p1 && (wr_addr_p1 == iss_addr)));

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for the writeback arbiter and busy scoreboard.
module tb_regfile_wb_arbiter;
    import regfile_pkg::*;

    logic              clk;
    logic              rst;
    logic              alu_valid;
    logic [ADDR_W-1:0] alu_addr;
    logic [DATA_W-1:0] alu_data;
    logic              alu_ready;
    logic              mem_valid;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_data;
    logic              mem_ready;
    logic              iss_valid;
    logic [ADDR_W-1:0] iss_addr;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic [NREG-1:0]   busy;
    logic              pc_wr_err;

    int n_cmp = 0;
    int n_bad = 0;

    regfile_wb_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .alu_valid (alu_valid),
        .alu_addr  (alu_addr),
        .alu_data  (alu_data),
        .alu_ready (alu_ready),
        .mem_valid (mem_valid),
        .mem_addr  (mem_addr),
        .mem_data  (mem_data),
        .mem_ready (mem_ready),
        .iss_valid (iss_valid),
        .iss_addr  (iss_addr),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .busy      (busy),
        .pc_wr_err (pc_wr_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance past the next rising edge; inputs are driven and registered outputs sampled here.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Move to the falling edge to observe combinational ready.
    task automatic mid();
        @(negedge clk);
    endtask

    task automatic alu(input logic v, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        alu_valid = v; alu_addr = a; alu_data = d;
    endtask

    task automatic mem(input logic v, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        mem_valid = v; mem_addr = a; mem_data = d;
    endtask

    task automatic chk_wr(input string tag, input logic en, input logic [ADDR_W-1:0] a,
                          input logic [DATA_W-1:0] d);
        chk({tag, "_en"}, 32'(wr_en), 32'(en));
        chk({tag, "_addr"}, 32'(wr_addr), 32'(a));
        chk({tag, "_data"}, wr_data, d);
    endtask

    task automatic chk_gnt(input string tag, input logic a, input logic m);
        mid();
        chk({tag, "_alu_rdy"}, 32'(alu_ready), 32'(a));
        chk({tag, "_mem_rdy"}, 32'(mem_ready), 32'(m));
    endtask

    initial begin
        rst = 1'b1;
        alu(0, 0, 0);
        mem(0, 0, 0);
        iss_valid = 1'b0;
        iss_addr  = '0;
        step();
        // Requests during reset must not be granted or change state.
        alu(1, 4'd3, 32'h1234_5678);
        mem(1, 4'd2, 32'h8765_4321);
        chk_gnt("rst_gnt", 1'b0, 1'b0);
        step();
        chk_wr("rst", 1'b0, 4'd0, 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_pcerr", 32'(pc_wr_err), 32'h0);
        rst = 1'b0;
        alu(0, 0, 0);
        mem(0, 0, 0);
        step();

        // Single ALU write r3.
        alu(1, 4'd3, 32'hDEAD_BEEF);
        chk_gnt("single", 1'b1, 1'b0);
        step();
        alu(0, 0, 0);
        chk_wr("single_wr", 1'b1, 4'd3, 32'hDEAD_BEEF);
        step();
        chk_wr("idle_hold", 1'b0, 4'd3, 32'hDEAD_BEEF);

        // Contested stream: ALU r1,r2,r6 vs MEM r4,r5.
        alu(1, 4'd1, 32'h11);
        mem(1, 4'd4, 32'h44);
        chk_gnt("rr0", 1'b1, 1'b0);
        step();
        chk_wr("rr0_wr", 1'b1, 4'd1, 32'h11);
        alu(1, 4'd2, 32'h22);
        chk_gnt("rr1", 1'b0, 1'b1);
        step();
        chk_wr("rr1_wr", 1'b1, 4'd4, 32'h44);
        mem(1, 4'd5, 32'h55);
        chk_gnt("rr2", 1'b1, 1'b0);
        step();
        chk_wr("rr2_wr", 1'b1, 4'd2, 32'h22);
        alu(1, 4'd6, 32'h66);
        chk_gnt("rr3", 1'b0, 1'b1);
        step();
        chk_wr("rr3_wr", 1'b1, 4'd5, 32'h55);
        mem(0, 0, 0);
        chk_gnt("rr4", 1'b1, 1'b0);
        step();
        alu(0, 0, 0);
        chk_wr("rr4_wr", 1'b1, 4'd6, 32'h66);

        // Scoreboard set, clear, and set-wins-over-clear.
        iss_valid = 1'b1; iss_addr = 4'd7;
        step();
        iss_valid = 1'b0;
        chk("sb_set", 32'(busy), 32'h0080);
        mem(1, 4'd7, 32'h77);
        chk_gnt("sb_w1", 1'b0, 1'b1);
        step();
        mem(0, 0, 0);
        chk_wr("sb_w1_wr", 1'b1, 4'd7, 32'h77);
        chk("sb_still_busy", 32'(busy), 32'h0080);
        step();
        chk("sb_clear", 32'(busy), 32'h0000);
        iss_valid = 1'b1; iss_addr = 4'd7;
        step();
        iss_valid = 1'b0;
        mem(1, 4'd7, 32'h78);
        step();
        mem(0, 0, 0);
        chk_wr("sb_w2_wr", 1'b1, 4'd7, 32'h78);
        iss_valid = 1'b1; iss_addr = 4'd7;
        step();
        iss_valid = 1'b0;
        chk("sb_set_wins", 32'(busy), 32'h0080);
        mem(1, 4'd7, 32'h79);
        step();
        mem(0, 0, 0);
        step();
        chk("sb_clear2", 32'(busy), 32'h0000);
        iss_valid = 1'b1; iss_addr = 4'd15;
        step();
        iss_valid = 1'b0;
        chk("sb_pc_ignored", 32'(busy), 32'h0000);

        // ALU request targeting the PC is consumed but never written.
        alu(1, 4'd15, 32'hCAFE_F00D);
        chk_gnt("pc", 1'b1, 1'b0);
        step();
        alu(0, 0, 0);
        chk_wr("pc_wr", 1'b0, 4'd7, 32'h79);
        chk("pc_err_pulse", 32'(pc_wr_err), 32'h1);
        chk("pc_busy", 32'(busy), 32'h0000);
        step();
        chk("pc_err_end", 32'(pc_wr_err), 32'h0);

        // MEM held against a streaming ALU is served on the very next cycle.
        alu(1, 4'd8, 32'h88);
        mem(1, 4'd9, 32'h99);
        chk_gnt("hold0", 1'b1, 1'b0);
        step();
        chk_wr("hold0_wr", 1'b1, 4'd8, 32'h88);
        alu(1, 4'd10, 32'hAA);
        chk_gnt("hold1", 1'b0, 1'b1);
        step();
        chk_wr("hold1_wr", 1'b1, 4'd9, 32'h99);
        mem(1, 4'd11, 32'hBB);
        chk_gnt("hold2", 1'b1, 1'b0);
        step();
        alu(0, 0, 0);
        mem(0, 0, 0);
        chk_wr("hold2_wr", 1'b1, 4'd10, 32'hAA);

        // Reset mid-operation with a write in flight and busy = 0x00F0.
        for (int r = 4; r < 8; r++) begin
            iss_valid = 1'b1; iss_addr = ADDR_W'(r);
            step();
        end
        iss_valid = 1'b0;
        alu(1, 4'd4, 32'h4444);
        step();
        alu(0, 0, 0);
        chk("mid_busy", 32'(busy), 32'h00F0);
        chk("mid_wren", 32'(wr_en), 32'h1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk_wr("mid_rst", 1'b0, 4'd0, 32'h0);
        chk("mid_rst_busy", 32'(busy), 32'h0000);
        alu(1, 4'd1, 32'h1010);
        mem(1, 4'd2, 32'h2020);
        chk_gnt("post_rst", 1'b1, 1'b0);
        step();
        alu(0, 0, 0);
        mem(0, 0, 0);
        chk_wr("post_rst_wr", 1'b1, 4'd1, 32'h1010);
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
